// File: rtl/ddio_tx_pkg.sv
// Shared types and constants for the DDIO transmit gearbox.
package ddio_tx_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_TRAIN,
        ST_IDLE,
        ST_DATA
    } state_t;

    // Per-bit training levels; replicated across each lane by the user.
    localparam logic TRAIN_D0 = 1'b1;
    localparam logic TRAIN_D1 = 1'b0;

endpackage

// File: rtl/ddio_tx_gearbox.sv
// Slices wide words into d0/d1 beat pairs for the c_x1 DDIO serializer, with
// post-lock training burst when DDIO_TX_GEARBOX_TRAIN_EN is defined.
module ddio_tx_gearbox
    import ddio_tx_pkg::*;
#(
    parameter int   DW        = 1,
    parameter int   RATIO     = 4,
    parameter logic INIT      = 1'b0,
    parameter int   TRAIN_LEN = 16
) (
    input  logic                    c_x1,
    input  logic                    arst_c_x1,
    input  logic                    lock,
    input  logic                    train_req,
    input  logic [2*DW*RATIO-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DW-1:0]           d0,
    output logic [DW-1:0]           d1,
    output logic                    busy
);

    localparam int W  = 2*DW*RATIO;
    localparam int BW = 2*DW;
    localparam int SW = W - BW;
    localparam int CW = $clog2(RATIO);

    state_t        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [DW-1:0] d0_d, d1_d;
    logic          busy_d;
    logic          train_pend_q, train_pend_d;
    logic          train_go;
    logic          last_beat;
    logic          accept;

`ifdef DDIO_TX_GEARBOX_TRAIN_EN
    localparam int TW = $clog2(TRAIN_LEN+1);
    logic [TW-1:0] train_cnt_q, train_cnt_d;

    assign train_go = train_pend_q | train_req;
`else
    logic unused_train_cfg;

    assign unused_train_cfg = train_req ^ (TRAIN_LEN == 0);
    assign train_go         = train_pend_q;
`endif

    // beat_q is the index of the next beat to emit; it wraps to zero while the
    // final beat of a word is on d0/d1, which is when a new word may be taken.
    assign last_beat = (state_q == ST_DATA) && (beat_q == '0);
    assign s_ready   = lock & ~train_go & ((state_q == ST_IDLE) | last_beat);
    assign accept    = s_valid & s_ready;

    // NOTE: every signal gets a hold value first so no path leaves one unassigned
    // and infers a latch; lock low therefore freezes all state for free.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        shift_d      = shift_q;
        d0_d         = d0;
        d1_d         = d1;
        train_pend_d = train_pend_q;
`ifdef DDIO_TX_GEARBOX_TRAIN_EN
        train_cnt_d  = train_cnt_q;
`endif
        if (lock) begin
            case (state_q)
                ST_RESET: begin
`ifdef DDIO_TX_GEARBOX_TRAIN_EN
                    state_d     = ST_TRAIN;
                    d0_d        = {DW{TRAIN_D0}};
                    d1_d        = {DW{TRAIN_D1}};
                    train_cnt_d = TW'(1);
`else
                    state_d     = ST_IDLE;
                    d0_d        = {DW{INIT}};
                    d1_d        = {DW{INIT}};
`endif
                end
                ST_TRAIN: begin
`ifdef DDIO_TX_GEARBOX_TRAIN_EN
                    if (train_cnt_q == TW'(TRAIN_LEN)) begin
                        state_d      = ST_IDLE;
                        d0_d         = {DW{INIT}};
                        d1_d         = {DW{INIT}};
                        train_cnt_d  = '0;
                        train_pend_d = 1'b0;
                    end else begin
                        d0_d         = {DW{TRAIN_D0}};
                        d1_d         = {DW{TRAIN_D1}};
                        train_cnt_d  = train_cnt_q + TW'(1);
                    end
`else
                    state_d = ST_IDLE;
                    d0_d    = {DW{INIT}};
                    d1_d    = {DW{INIT}};
`endif
                end
                ST_IDLE: begin
                    d0_d = {DW{INIT}};
                    d1_d = {DW{INIT}};
`ifdef DDIO_TX_GEARBOX_TRAIN_EN
                    if (train_go) begin
                        state_d     = ST_TRAIN;
                        d0_d        = {DW{TRAIN_D0}};
                        d1_d        = {DW{TRAIN_D1}};
                        train_cnt_d = TW'(1);
                    end else
`endif
                    if (accept) begin
                        state_d = ST_DATA;
                        d0_d    = s_data[0  +: DW];
                        d1_d    = s_data[DW +: DW];
                        shift_d = s_data[W-1:BW];
                        beat_d  = CW'(1);
                    end
                end
                ST_DATA: begin
`ifdef DDIO_TX_GEARBOX_TRAIN_EN
                    if (train_req) train_pend_d = 1'b1;
`endif
                    if (!last_beat) begin
                        d0_d    = shift_q[0  +: DW];
                        d1_d    = shift_q[DW +: DW];
                        shift_d = shift_q >> BW;
                        beat_d  = (beat_q == CW'(RATIO-1)) ? '0 : beat_q + CW'(1);
                    end else if (accept) begin
                        d0_d    = s_data[0  +: DW];
                        d1_d    = s_data[DW +: DW];
                        shift_d = s_data[W-1:BW];
                        beat_d  = CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        d0_d    = {DW{INIT}};
                        d1_d    = {DW{INIT}};
                        beat_d  = '0;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge c_x1 or posedge arst_c_x1) begin
        if (arst_c_x1) begin
            state_q      <= ST_RESET;
            beat_q       <= '0;
            shift_q      <= '0;
            d0           <= {DW{INIT}};
            d1           <= {DW{INIT}};
            busy         <= 1'b1;
            train_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            shift_q      <= shift_d;
            d0           <= d0_d;
            d1           <= d1_d;
            busy         <= busy_d;
            train_pend_q <= train_pend_d;
        end
    end

`ifdef DDIO_TX_GEARBOX_TRAIN_EN
    always_ff @(posedge c_x1 or posedge arst_c_x1) begin
        if (arst_c_x1) train_cnt_q <= '0;
        else           train_cnt_q <= train_cnt_d;
    end
`endif

endmodule
